// File: rtl/uart_mmio_pkg.sv
// Shared register map and STATUS/CTRL layout for the memory-mapped UART.
package uart_mmio_pkg;

   localparam logic [4:0] OFS_TXDATA = 5'h00;
   localparam logic [4:0] OFS_RXDATA = 5'h04;
   localparam logic [4:0] OFS_STATUS = 5'h08;
   localparam logic [4:0] OFS_CTRL   = 5'h0C;
   localparam logic [4:0] OFS_BAUD   = 5'h10;

   localparam int ST_TX_EMPTY     = 0;
   localparam int ST_TX_FULL      = 1;
   localparam int ST_RX_EMPTY     = 2;
   localparam int ST_RX_FULL      = 3;
   localparam int ST_TX_OVF       = 4;
   localparam int ST_RX_OVF       = 5;
   localparam int ST_TX_COUNT_LSB = 8;
   localparam int ST_RX_COUNT_LSB = 16;

   localparam int CTRL_RX_POP   = 0;
   localparam int CTRL_TX_FLUSH = 1;
   localparam int CTRL_RX_FLUSH = 2;
   localparam int CTRL_OVF_CLR  = 3;

   typedef struct packed {
      logic [7:0] reserved_hi;
      logic [7:0] rx_count;
      logic [7:0] tx_count;
      logic [1:0] reserved_lo;
      logic       rx_ovf;
      logic       tx_ovf;
      logic       rx_full;
      logic       rx_empty;
      logic       tx_full;
      logic       tx_empty;
   } status_t;

endpackage

// File: rtl/uart_mmio_if.sv
// CPU data-memory bus and uart_tx/uart_rx handshakes seen by the UART peripheral.
interface uart_mmio_if #(
   parameter int XLEN = 32
) ();

   logic [XLEN-1:0] dram_rd_addr_i;
   logic [XLEN-1:0] dram_wr_addr_i;
   logic [XLEN-1:0] dram_wr_data_i;
   logic [3:0]      dram_wr_byte_en_i;
   logic            mmio_rd_hit_o;
   logic [XLEN-1:0] mmio_rd_data_o;
   logic [7:0]      uart_rx_data_i;
   logic            uart_rx_data_vld_i;
   logic            uart_rx_data_rdy_o;
   logic [7:0]      uart_tx_data_o;
   logic            uart_tx_data_vld_o;
   logic            uart_tx_data_rdy_i;
   logic [XLEN-1:0] uart_baud_div_o;

   modport slave (
      input  dram_rd_addr_i, dram_wr_addr_i, dram_wr_data_i, dram_wr_byte_en_i,
      input  uart_rx_data_i, uart_rx_data_vld_i, uart_tx_data_rdy_i,
      output mmio_rd_hit_o, mmio_rd_data_o, uart_rx_data_rdy_o,
      output uart_tx_data_o, uart_tx_data_vld_o, uart_baud_div_o
   );

   modport master (
      output dram_rd_addr_i, dram_wr_addr_i, dram_wr_data_i, dram_wr_byte_en_i,
      output uart_rx_data_i, uart_rx_data_vld_i, uart_tx_data_rdy_i,
      input  mmio_rd_hit_o, mmio_rd_data_o, uart_rx_data_rdy_o,
      input  uart_tx_data_o, uart_tx_data_vld_o, uart_baud_div_o
   );

endinterface

// File: rtl/uart_mmio_fifo.sv
// Synchronous byte FIFO with flush, push-while-full-and-popping, and a dropped-push flag.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A flush wins over everything; a push into a full FIFO only fits if the head leaves this cycle.
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty && !flush;
   assign do_push  = push && !flush && (!full || do_pop);
   assign drop     = push && !flush && !do_push;
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: maps a 32-byte window onto TX/RX FIFOs, STATUS, CTRL and BAUD registers.
module uart_mmio
   import uart_mmio_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] BASE_ADDR    = 32'h0001_0000,
   parameter int              FIFO_DEPTH   = 16,
   parameter logic [XLEN-1:0] BAUD_DIV_RST = 32'd107
) (
   input  logic      clk_i,
   input  logic      rst_n_i,
   input  logic      en_i,
   uart_mmio_if.slave bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic            wr_hit, rd_hit, ctrl_wr;
   logic [4:0]      wr_ofs, rd_ofs;
   logic            tx_push, tx_pop, tx_flush, tx_full, tx_empty, tx_drop, tx_vld;
   logic            rx_push, rx_pop, rx_flush, rx_full, rx_empty, rx_drop, rx_rdy;
   logic            ovf_clr, tx_ovf, rx_ovf;
   logic [CW-1:0]   tx_count, rx_count;
   logic [7:0]      tx_head, rx_head;
   logic [XLEN-1:0] baud, rd_value, rd_data_q;
   logic            rd_hit_q;
   status_t         status;
   logic            unused_addr_bits;

   assign wr_ofs  = {bus.dram_wr_addr_i[4:2], 2'b00};
   assign rd_ofs  = {bus.dram_rd_addr_i[4:2], 2'b00};
   assign wr_hit  = en_i && (bus.dram_wr_addr_i[XLEN-1:5] == BASE_ADDR[XLEN-1:5])
                    && (bus.dram_wr_byte_en_i != 4'b0000);
   assign rd_hit  = (bus.dram_rd_addr_i[XLEN-1:5] == BASE_ADDR[XLEN-1:5]);
   assign ctrl_wr = wr_hit && (wr_ofs == OFS_CTRL) && bus.dram_wr_byte_en_i[0];
   assign tx_push = wr_hit && (wr_ofs == OFS_TXDATA) && bus.dram_wr_byte_en_i[0];

   // Dropping en_i behaves like a flush of both FIFOs so they come back empty.
   assign rx_pop   = ctrl_wr && bus.dram_wr_data_i[CTRL_RX_POP];
   assign tx_flush = !en_i || (ctrl_wr && bus.dram_wr_data_i[CTRL_TX_FLUSH]);
   assign rx_flush = !en_i || (ctrl_wr && bus.dram_wr_data_i[CTRL_RX_FLUSH]);
   assign ovf_clr  = ctrl_wr && bus.dram_wr_data_i[CTRL_OVF_CLR];

   assign tx_vld  = en_i && !tx_empty;
   assign tx_pop  = tx_vld && bus.uart_tx_data_rdy_i;
   assign rx_rdy  = en_i && rst_n_i;
   assign rx_push = rx_rdy && bus.uart_rx_data_vld_i;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk_i), .rst_n(rst_n_i),
      .push(tx_push), .push_data(bus.dram_wr_data_i[7:0]), .pop(tx_pop), .flush(tx_flush),
      .pop_data(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count), .drop(tx_drop)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk_i), .rst_n(rst_n_i),
      .push(rx_push), .push_data(bus.uart_rx_data_i), .pop(rx_pop), .flush(rx_flush),
      .pop_data(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count), .drop(rx_drop)
   );

   // A new overflow in the same cycle as ovf_clr must leave the flag set.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tx_ovf <= 1'b0;
         rx_ovf <= 1'b0;
      end else if (!en_i) begin
         tx_ovf <= 1'b0;
         rx_ovf <= 1'b0;
      end else begin
         tx_ovf <= tx_drop || (tx_ovf && !ovf_clr);
         rx_ovf <= rx_drop || (rx_ovf && !ovf_clr);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         baud <= BAUD_DIV_RST;
      end else if (wr_hit && (wr_ofs == OFS_BAUD)) begin
         for (int b = 0; b < XLEN / 8; b++) begin
            if (bus.dram_wr_byte_en_i[b]) baud[8*b +: 8] <= bus.dram_wr_data_i[8*b +: 8];
         end
      end
   end

   always_comb begin
      status          = '0;
      status.tx_empty = tx_empty;
      status.tx_full  = tx_full;
      status.rx_empty = rx_empty;
      status.rx_full  = rx_full;
      status.tx_ovf   = tx_ovf;
      status.rx_ovf   = rx_ovf;
      status.tx_count = 8'(tx_count);
      status.rx_count = 8'(rx_count);
   end

   always_comb begin
      rd_value = '0;
      case (rd_ofs)
         OFS_RXDATA: rd_value = XLEN'(rx_head);
         OFS_STATUS: rd_value = XLEN'(status);
         OFS_BAUD:   rd_value = baud;
         default:    rd_value = '0;
      endcase
   end

   // Sampling the pre-edge register values gives read-before-write on a same-cycle collision.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_hit_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_hit_q  <= rd_hit;
         rd_data_q <= rd_hit ? rd_value : '0;
      end
   end

   assign bus.mmio_rd_hit_o      = rd_hit_q;
   assign bus.mmio_rd_data_o     = rd_data_q;
   assign bus.uart_tx_data_o     = tx_head;
   assign bus.uart_tx_data_vld_o = tx_vld;
   assign bus.uart_rx_data_rdy_o = rx_rdy;
   assign bus.uart_baud_div_o    = baud;

   assign unused_addr_bits = ^{bus.dram_rd_addr_i[1:0], bus.dram_wr_addr_i[1:0]};

endmodule

// File: tb/tb_uart_mmio.sv
// Randomized bench for uart_mmio: a queue-based model of the register map predicts every output.
module tb_uart_mmio;

   localparam int          XLEN  = 32;
   localparam int          DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0001_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic en    = 1'b0;
   logic tx_rdy_lvl = 1'b0;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  txq[$];
   logic [7:0]  rxq[$];
   logic        tx_ovf_m, rx_ovf_m;
   logic [31:0] baud_m;
   logic        exp_hit;
   logic [31:0] exp_rd;
   logic [31:0] baud_saved;

   always #5 clk = ~clk;

   uart_mmio_if #(.XLEN(XLEN)) bus ();

   uart_mmio #(
      .XLEN(XLEN), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .BAUD_DIV_RST(32'd107)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .bus(bus)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   function automatic logic [31:0] modelReg(input logic [31:0] addr);
      if (addr[31:5] != BASE[31:5]) return 32'h0;
      case (addr[4:2])
         3'd1: return (rxq.size() > 0) ? {24'h0, rxq[0]} : 32'h0;
         3'd2: return {8'h0, 8'(rxq.size()), 8'(txq.size()), 2'b00, rx_ovf_m, tx_ovf_m,
                       rxq.size() == DEPTH, rxq.size() == 0, txq.size() == DEPTH, txq.size() == 0};
         3'd4: return baud_m;
         default: return 32'h0;
      endcase
   endfunction

   task automatic modelReset();
      txq.delete();
      rxq.delete();
      tx_ovf_m = 1'b0;
      rx_ovf_m = 1'b0;
      baud_m   = 32'd107;
      exp_hit  = 1'b0;
      exp_rd   = 32'h0;
   endtask

   // One clock of the reference: reads see the state before this edge's updates.
   task automatic modelStep();
      logic [31:0] wa, wd;
      logic [3:0]  be;
      bit wr_hit, ctrl, tx_push, rx_pop, tx_fl, rx_fl, clr, new_tx_ovf, new_rx_ovf;
      exp_hit = (bus.dram_rd_addr_i[31:5] == BASE[31:5]);
      exp_rd  = modelReg(bus.dram_rd_addr_i);
      if (!en) begin
         txq.delete();
         rxq.delete();
         tx_ovf_m = 1'b0;
         rx_ovf_m = 1'b0;
         return;
      end
      wa = bus.dram_wr_addr_i;
      wd = bus.dram_wr_data_i;
      be = bus.dram_wr_byte_en_i;
      wr_hit  = (wa[31:5] == BASE[31:5]) && (be != 4'b0);
      tx_push = wr_hit && (wa[4:2] == 3'd0) && be[0];
      ctrl    = wr_hit && (wa[4:2] == 3'd3) && be[0];
      rx_pop  = ctrl && wd[0];
      tx_fl   = ctrl && wd[1];
      rx_fl   = ctrl && wd[2];
      clr     = ctrl && wd[3];
      if (wr_hit && (wa[4:2] == 3'd4))
         for (int b = 0; b < 4; b++) if (be[b]) baud_m[8*b +: 8] = wd[8*b +: 8];
      new_tx_ovf = 1'b0;
      new_rx_ovf = 1'b0;
      if (tx_fl) txq.delete();
      else begin
         if (txq.size() > 0 && bus.uart_tx_data_rdy_i) void'(txq.pop_front());
         if (tx_push) begin
            if (txq.size() < DEPTH) txq.push_back(wd[7:0]);
            else new_tx_ovf = 1'b1;
         end
      end
      if (rx_fl) rxq.delete();
      else begin
         if (rx_pop && rxq.size() > 0) void'(rxq.pop_front());
         if (bus.uart_rx_data_vld_i) begin
            if (rxq.size() < DEPTH) rxq.push_back(bus.uart_rx_data_i);
            else new_rx_ovf = 1'b1;
         end
      end
      if (clr) begin
         tx_ovf_m = 1'b0;
         rx_ovf_m = 1'b0;
      end
      tx_ovf_m = tx_ovf_m | new_tx_ovf;
      rx_ovf_m = rx_ovf_m | new_rx_ovf;
   endtask

   task automatic checkAll();
      checkOutput("rd_hit", bus.mmio_rd_hit_o, exp_hit);
      checkOutput("rd_data", bus.mmio_rd_data_o, exp_rd);
      checkOutput("tx_vld", bus.uart_tx_data_vld_o, en && (txq.size() > 0));
      checkOutput("tx_data", bus.uart_tx_data_o, (txq.size() > 0) ? txq[0] : 8'h00);
      checkOutput("rx_rdy", bus.uart_rx_data_rdy_o, en);
      checkOutput("baud", bus.uart_baud_div_o, baud_m);
   endtask

   task automatic applyStimulus(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd,
                                input logic [3:0] be, input logic rx_vld, input logic [7:0] rx_data,
                                input logic tx_rdy);
      bus.dram_rd_addr_i     = ra;
      bus.dram_wr_addr_i     = wa;
      bus.dram_wr_data_i     = wd;
      bus.dram_wr_byte_en_i  = be;
      bus.uart_rx_data_vld_i = rx_vld;
      bus.uart_rx_data_i     = rx_data;
      bus.uart_tx_data_rdy_i = tx_rdy;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkAll();
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      applyStimulus(32'h0, addr, data, be, 1'b0, 8'h00, tx_rdy_lvl);
   endtask

   task automatic load(input logic [31:0] addr);
      applyStimulus(addr, 32'h0, 32'h0, 4'b0000, 1'b0, 8'h00, tx_rdy_lvl);
   endtask

   task automatic inject(input logic [7:0] data);
      applyStimulus(32'h0, 32'h0, 32'h0, 4'b0000, 1'b1, data, tx_rdy_lvl);
   endtask

   task automatic randomCycle();
      logic [31:0] ra, wa, wd;
      logic [3:0]  be;
      int          sel;
      ra = BASE | 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) ra = ra ^ 32'h0100_0000;
      sel = $urandom_range(0, 19);
      wd  = $urandom;
      be  = 4'($urandom_range(1, 15));
      if (sel < 8) wa = BASE;
      else if (sel < 10) begin
         wa = BASE + 32'h0C;
         wd = {28'h0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1};
      end
      else if (sel == 10) wa = BASE + 32'h10;
      else if (sel == 11) wa = BASE + 32'h14 + 32'(4 * $urandom_range(0, 2));
      else if (sel == 12) begin
         wa = BASE;
         be = 4'b0000;
      end
      else begin
         wa = 32'h0;
         be = 4'b0000;
      end
      if ($urandom_range(0, 3) == 0) wa[1:0] = 2'($urandom);
      en = ($urandom_range(0, 39) != 0);
      applyStimulus(ra, wa, wd, be, $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 2) == 0);
   endtask

   initial begin
      bus.dram_rd_addr_i     = 32'h0;
      bus.dram_wr_addr_i     = 32'h0;
      bus.dram_wr_data_i     = 32'h0;
      bus.dram_wr_byte_en_i  = 4'b0000;
      bus.uart_rx_data_i     = 8'h00;
      bus.uart_rx_data_vld_i = 1'b0;
      bus.uart_tx_data_rdy_i = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      checkOutput("reset_rd_hit", bus.mmio_rd_hit_o, 1'b0);
      checkOutput("reset_rd_data", bus.mmio_rd_data_o, 32'h0);
      checkOutput("reset_tx_vld", bus.uart_tx_data_vld_o, 1'b0);
      checkOutput("reset_tx_data", bus.uart_tx_data_o, 8'h00);
      checkOutput("reset_rx_rdy", bus.uart_rx_data_rdy_o, 1'b0);
      checkOutput("reset_baud", bus.uart_baud_div_o, 32'd107);
      rst_n = 1'b1;

      load(BASE + 32'h10);
      checkOutput("t1_baud_hit", bus.mmio_rd_hit_o, 1'b1);
      checkOutput("t1_baud_read", bus.mmio_rd_data_o, 32'd107);
      load(BASE + 32'h08);
      checkOutput("t1_status", bus.mmio_rd_data_o, 32'h0000_0005);

      en = 1'b1;
      tx_rdy_lvl = 1'b0;
      store(BASE, 32'h41, 4'b0001);
      store(BASE, 32'h42, 4'b0001);
      store(BASE, 32'h43, 4'b0001);
      load(BASE + 32'h08);
      checkOutput("t2_tx_count", bus.mmio_rd_data_o[15:8], 8'd3);
      checkOutput("t2_head0", bus.uart_tx_data_o, 8'h41);
      tx_rdy_lvl = 1'b1;
      load(32'h0);
      checkOutput("t2_head1", bus.uart_tx_data_o, 8'h42);
      load(32'h0);
      checkOutput("t2_head2", bus.uart_tx_data_o, 8'h43);
      load(32'h0);
      checkOutput("t2_drained_vld", bus.uart_tx_data_vld_o, 1'b0);
      tx_rdy_lvl = 1'b0;
      load(BASE + 32'h08);
      checkOutput("t2_tx_empty", bus.mmio_rd_data_o[0], 1'b1);

      for (int i = 0; i < 17; i++) store(BASE, 32'(i), 4'b0001);
      load(BASE + 32'h08);
      checkOutput("t3_tx_count", bus.mmio_rd_data_o[15:8], 8'd16);
      checkOutput("t3_tx_full", bus.mmio_rd_data_o[1], 1'b1);
      checkOutput("t3_tx_ovf", bus.mmio_rd_data_o[4], 1'b1);
      store(BASE + 32'h0C, 32'h8, 4'b0001);
      load(BASE + 32'h08);
      checkOutput("t3_ovf_cleared", bus.mmio_rd_data_o[4], 1'b0);
      checkOutput("t3_count_kept", bus.mmio_rd_data_o[15:8], 8'd16);
      store(BASE + 32'h0C, 32'h2, 4'b0001);
      load(BASE + 32'h08);
      checkOutput("t3_flushed", bus.mmio_rd_data_o[0], 1'b1);

      for (int i = 0; i < 17; i++) inject(8'(8'h10 + i));
      load(BASE + 32'h08);
      checkOutput("t4_rx_count", bus.mmio_rd_data_o[23:16], 8'd16);
      checkOutput("t4_rx_ovf", bus.mmio_rd_data_o[5], 1'b1);
      load(BASE + 32'h04);
      checkOutput("t4_rx_head", bus.mmio_rd_data_o, 32'h10);
      store(BASE + 32'h0C, 32'h1, 4'b0001);
      load(BASE + 32'h04);
      checkOutput("t4_rx_next", bus.mmio_rd_data_o, 32'h11);
      load(BASE + 32'h08);
      checkOutput("t4_rx_count15", bus.mmio_rd_data_o[23:16], 8'd15);
      store(BASE + 32'h0C, 32'h8, 4'b0001);
      inject(8'h21);
      applyStimulus(32'h0, BASE + 32'h0C, 32'h1, 4'b0001, 1'b1, 8'h22, 1'b0);
      load(BASE + 32'h08);
      checkOutput("t4_pop_push_count", bus.mmio_rd_data_o[23:16], 8'd16);
      checkOutput("t4_pop_push_no_ovf", bus.mmio_rd_data_o[5], 1'b0);

      store(BASE + 32'h10, 32'h0000_00C8, 4'b0001);
      checkOutput("t5_baud_byte0", bus.uart_baud_div_o, 32'd200);
      store(BASE + 32'h10, 32'h0000_0100, 4'b0010);
      checkOutput("t5_baud_byte1", bus.uart_baud_div_o, 32'd456);
      applyStimulus(32'h0002_0010, 32'h0002_0010, 32'hFFFF_FFFF, 4'b1111, 1'b0, 8'h00, 1'b0);
      checkOutput("t5_miss_baud", bus.uart_baud_div_o, 32'd456);
      checkOutput("t5_miss_hit", bus.mmio_rd_hit_o, 1'b0);

      repeat (800) randomCycle();
      en = 1'b1;

      tx_rdy_lvl = 1'b0;
      store(BASE + 32'h0C, 32'h6, 4'b0001);
      for (int i = 0; i < 5; i++) store(BASE, 32'(8'hA0 + i), 4'b0001);
      for (int i = 0; i < 4; i++) inject(8'(8'hB0 + i));
      baud_saved = baud_m;
      en = 1'b0;
      load(32'h0);
      checkOutput("t6_en_low_vld", bus.uart_tx_data_vld_o, 1'b0);
      checkOutput("t6_en_low_rdy", bus.uart_rx_data_rdy_o, 1'b0);
      checkOutput("t6_baud_kept", bus.uart_baud_div_o, baud_saved);
      en = 1'b1;
      load(BASE + 32'h08);
      checkOutput("t6_status_empty", bus.mmio_rd_data_o, 32'h0000_0005);

      store(BASE + 32'h10, 32'h0000_01C8, 4'b1111);
      for (int i = 0; i < 3; i++) store(BASE, 32'(8'h55 + i), 4'b0001);
      tx_rdy_lvl = 1'b1;
      load(BASE + 32'h10);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_rd_hit", bus.mmio_rd_hit_o, 1'b0);
      checkOutput("t6_rst_rd_data", bus.mmio_rd_data_o, 32'h0);
      checkOutput("t6_rst_tx_vld", bus.uart_tx_data_vld_o, 1'b0);
      checkOutput("t6_rst_tx_data", bus.uart_tx_data_o, 8'h00);
      checkOutput("t6_rst_rx_rdy", bus.uart_rx_data_rdy_o, 1'b0);
      checkOutput("t6_rst_baud", bus.uart_baud_div_o, 32'd107);
      modelReset();
      tx_rdy_lvl = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      load(BASE + 32'h08);
      checkOutput("t6_post_reset_status", bus.mmio_rd_data_o, 32'h0000_0005);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
Memory-mapped UART peripheral on the hxd32 data-memory bus. It turns CPU stores and loads in a 32-byte window into TX/RX byte FIFOs, status, control and baud-divider registers, and connects to the existing uart_tx/uart_rx vld/rdy handshakes. It runs on sys_clk/sys_rst_n. The top level multiplexes its UART handshakes with the loader using en_i, which is tied to the CPU reset.

Parameters:
XLEN, 32, bus address/data width
BASE_ADDR, 32'h0001_0000, window base; must be 32-byte aligned
FIFO_DEPTH, 16, entries per FIFO; power of 2, range 2..128
BAUD_DIV_RST, 32'd107, reset value of BAUD register

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
en_i  in  1  peripheral enable (CPU out of reset)
dram_rd_addr_i  in  XLEN  CPU load address
dram_wr_addr_i  in  XLEN  CPU store address
dram_wr_data_i  in  XLEN  CPU store data
dram_wr_byte_en_i  in  4  CPU store byte enables
mmio_rd_hit_o  out  1  registered: previous-cycle load hit the window
mmio_rd_data_o  out  XLEN  registered load data
uart_rx_data_i  in  8  received byte
uart_rx_data_vld_i  in  1  received byte valid
uart_rx_data_rdy_o  out  1  ready to accept byte
uart_tx_data_o  out  8  byte to transmit
uart_tx_data_vld_o  out  1  TX byte valid
uart_tx_data_rdy_i  in  1  transmitter ready
uart_baud_div_o  out  XLEN  baud divider for uart_rx/uart_tx

Behaviour:
- Hit decoding: addr[XLEN-1:5] == BASE_ADDR[XLEN-1:5]. Offset is addr[4:2]; addr[1:0] is ignored. A write is any store hit with byte_en != 0.
- Register map:
  - 0x00 TXDATA: write with byte_en[0] pushes data[7:0]. Reads return 0.
  - 0x04 RXDATA: reads return {24'b0, rx head}, or 0 when empty. Reading has no side effect.
  - 0x08 STATUS (read-only): [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] tx_ovf, [5] rx_ovf, [15:8] tx_count, [23:16] rx_count; all other bits 0.
  - 0x0C CTRL (write-only, self-clearing, reads return 0). Bits are acted on only when byte_en[0] is set: [0] rx_pop, [1] tx_flush, [2] rx_flush, [3] ovf_clr.
  - 0x10 BAUD: read/write, per-byte enables.
  - 0x14..0x1C: reads return 0; writes are ignored.
- Read path: one-cycle latency. mmio_rd_hit_o and mmio_rd_data_o take the hit flag and register value sampled at the rising edge; mmio_rd_data_o is 0 when there is no hit. If a read and a write to the same register fall in one cycle, the read returns the pre-write value.
- TX FIFO:
  - uart_tx_data_o is the head byte; uart_tx_data_vld_o = en_i & ~tx_empty.
  - A pop occurs when vld & rdy.
  - A push is accepted if the FIFO is not full or a pop occurs in the same cycle.
  - A push that is not accepted is dropped and sets tx_ovf (sticky).
- RX FIFO:
  - uart_rx_data_rdy_o = en_i after reset (0 during reset); it does not depend on fullness.
  - A byte is captured when vld & rdy. If the FIFO is full and no rx_pop occurs in the same cycle, the byte is dropped and rx_ovf is set (sticky).
  - rx_pop on an empty FIFO is a no-op.
- Priority, highest first: flush > push/pop. A flush discards any push arriving in the same cycle. ovf_clr in the same cycle as a new overflow leaves the flag set.
- Counts are $clog2(FIFO_DEPTH)+1 bits wide, zero-extended into STATUS. Pointers wrap modulo FIFO_DEPTH.
- en_i low:
  - Both FIFOs and both ovf flags are synchronously cleared.
  - uart_tx_data_vld_o and uart_rx_data_rdy_o are 0.
  - Writes are ignored, but reads still work (BAUD remains readable).
  - BAUD is retained.
- Reset values:
  - FIFOs empty, flags 0, mmio_rd_hit_o = 0, mmio_rd_data_o = 0.
  - uart_rx_data_rdy_o = 0, uart_tx_data_vld_o = 0, uart_tx_data_o = 0.
  - BAUD = BAUD_DIV_RST.
- Reset asserted mid-transfer: all state returns to the reset values asynchronously. A byte partly handed off is lost.

Decomposition:
- Package uart_mmio_pkg:
  - register offset constants (OFS_TXDATA, OFS_RXDATA, OFS_STATUS, OFS_CTRL, OFS_BAUD)
  - STATUS bit indices
  - CTRL bit indices
  - packed struct for STATUS
- Sub-module sync_fifo, instantiated twice (TX, RX):
  - parameters WIDTH and DEPTH
  - ports: push/pop/flush; outputs data, full, empty, count
  - simultaneous push+pop is allowed when full
  - dropped-push indication

Test Plan:
1. After reset, load 0x0001_0010 → next cycle mmio_rd_hit_o=1, data=107. Load 0x0001_0008 → data=0x0000_0005 (tx_empty, rx_empty).
2. en_i=1, uart_tx_data_rdy_i=0, store 0x41, 0x42, 0x43 to TXDATA → STATUS tx_count=3. Raise rdy for 3 cycles → uart_tx_data_o sequence 0x41, 0x42, 0x43 with vld=1, then vld=0 and tx_empty=1.
3. Push 17 bytes with rdy=0 → tx_count=16, tx_full=1, tx_ovf=1. Write CTRL=0x8 → tx_ovf=0, count still 16. Write CTRL=0x2 → tx_empty=1.
4. Inject RX bytes 0x10..0x1F plus one more (0x20) → rx_count=16, rx_ovf=1, RXDATA=0x10. CTRL=0x1 → RXDATA=0x11, rx_count=15. An inject coinciding with rx_pop while full is accepted, no ovf.
5. Store 0x0000_00C8 to BAUD with byte_en=4'b0001 → uart_baud_div_o=200. Store with byte_en=4'b0010 and data 0x0000_0100 → 456 (0x1C8). A store to 0x0002_0010 (miss) leaves the value unchanged and mmio_rd_hit_o=0.
6. Fill FIFOs, drop en_i for 1 cycle → both FIFOs empty, vld/rdy=0, BAUD kept. Assert rst_n_i mid-TX-drain → all outputs reach reset values immediately.
